// File: rtl/tnew_scoreboard.sv
// Tnew/Tuse hazard scoreboard for the pipelined MIPS core.
// Tracks {valid, we, rd, tnew} for each post-D stage and a mult/div busy counter,
// and derives the D-stage stall and the forward selects from them.
module tnew_scoreboard #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned TNEW_W   = 2,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned SEL_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              d_valid_i,
  input  logic              d_we_i,
  input  logic [REG_W-1:0]  d_rd_i,
  input  logic [TNEW_W-1:0] d_tnew_i,
  input  logic [REG_W-1:0]  d_rs_i,
  input  logic [REG_W-1:0]  d_rt_i,
  input  logic [TNEW_W-1:0] d_tuse_rs_i,
  input  logic [TNEW_W-1:0] d_tuse_rt_i,
  input  logic              d_md_start_i,
  input  logic              d_md_div_i,
  input  logic              d_md_use_i,
  output logic              stall_o,
  output logic [SEL_W-1:0]  fwd_rs_sel_o,
  output logic [SEL_W-1:0]  fwd_rt_sel_o,
  output logic              md_busy_o
);

  localparam int unsigned MdW = $clog2(DIV_LAT + 1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] we_q, we_d;
  logic [REG_W-1:0]  rd_q   [STAGES];
  logic [REG_W-1:0]  rd_d   [STAGES];
  logic [TNEW_W-1:0] tnew_q [STAGES];
  logic [TNEW_W-1:0] tnew_d [STAGES];
  logic [MdW-1:0]    md_cnt_q, md_cnt_d;

  logic              rs_hit, rt_hit;
  logic [TNEW_W-1:0] rs_tnew, rt_tnew;
  logic [SEL_W-1:0]  rs_sel, rt_sel;
  logic              rs_stall, rt_stall;

  // Youngest-match search per source; scanning oldest to youngest lets the youngest win.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_tnew = '0;
    rt_tnew = '0;
    rs_sel  = '0;
    rt_sel  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (valid_q[i] && we_q[i] && (rd_q[i] == d_rs_i) && (d_rs_i != '0)) begin
        rs_hit  = 1'b1;
        rs_tnew = tnew_q[i];
        rs_sel  = SEL_W'(i + 1);
      end
      if (valid_q[i] && we_q[i] && (rd_q[i] == d_rt_i) && (d_rt_i != '0)) begin
        rt_hit  = 1'b1;
        rt_tnew = tnew_q[i];
        rt_sel  = SEL_W'(i + 1);
      end
    end
  end

  // Stall and forward-select decode; an all-ones Tuse marks an unused source.
  always_comb begin
    rs_stall     = rs_hit && (d_tuse_rs_i != '1) && (rs_tnew > d_tuse_rs_i);
    rt_stall     = rt_hit && (d_tuse_rt_i != '1) && (rt_tnew > d_tuse_rt_i);
    md_busy_o    = (md_cnt_q != '0);
    stall_o      = d_valid_i && (rs_stall || rt_stall || (d_md_use_i && md_busy_o));
    fwd_rs_sel_o = (rs_hit && (rs_tnew == '0)) ? rs_sel : '0;
    fwd_rt_sel_o = (rt_hit && (rt_tnew == '0)) ? rt_sel : '0;
  end

  // Pipeline advance: entry 0 takes D (or a bubble on stall), older entries shift and count down.
  always_comb begin
    valid_d   = '0;
    we_d      = '0;
    rd_d[0]   = d_rd_i;
    tnew_d[0] = d_tnew_i;
    if (!stall_o) begin
      valid_d[0] = d_valid_i;
      we_d[0]    = d_we_i & d_valid_i;
    end
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      we_d[i]    = we_q[i-1];
      rd_d[i]    = rd_q[i-1];
      tnew_d[i]  = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TNEW_W'(1);
    end
  end

  // Mult/div latency counter; only loaded when the op actually leaves D.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (d_md_start_i && d_valid_i && !stall_o) begin
      md_cnt_d = d_md_div_i ? MdW'(DIV_LAT) : MdW'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MdW'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      we_q     <= '0;
      md_cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rd_q[i]   <= '0;
        tnew_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      we_q     <= we_d;
      md_cnt_q <= md_cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        rd_q[i]   <= rd_d[i];
        tnew_q[i] <= tnew_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tnew_scoreboard.sv
// Directed bench for tnew_scoreboard: hazard stalls, forwarding, shadowing, $0 and mult/div.
module tb_tnew_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       d_valid, d_we, d_md_start, d_md_div, d_md_use;
  logic [4:0] d_rd, d_rs, d_rt;
  logic [1:0] d_tnew, d_tuse_rs, d_tuse_rt;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int total = 0;
  int bad   = 0;

  tnew_scoreboard dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .d_valid_i    (d_valid),
    .d_we_i       (d_we),
    .d_rd_i       (d_rd),
    .d_tnew_i     (d_tnew),
    .d_rs_i       (d_rs),
    .d_rt_i       (d_rt),
    .d_tuse_rs_i  (d_tuse_rs),
    .d_tuse_rt_i  (d_tuse_rt),
    .d_md_start_i (d_md_start),
    .d_md_div_i   (d_md_div),
    .d_md_use_i   (d_md_use),
    .stall_o      (stall),
    .fwd_rs_sel_o (fwd_rs_sel),
    .fwd_rt_sel_o (fwd_rt_sel),
    .md_busy_o    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // D-stage stimulus; outputs settle 1 time unit later.
  task automatic set_d(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] tn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs,
                       input logic [1:0] urt, input logic ms, input logic md, input logic mu);
    d_valid = v; d_we = we; d_rd = rd; d_tnew = tn; d_rs = rs; d_rt = rt;
    d_tuse_rs = urs; d_tuse_rt = urt; d_md_start = ms; d_md_div = md; d_md_use = mu;
    #1;
  endtask

  task automatic idle();
    set_d(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 5'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if (fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL reset_fwd_rs got=%0d want=0", fwd_rs_sel); end
    total++; if (fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL reset_fwd_rt got=%0d want=0", fwd_rt_sel); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", md_busy); end
    rst_n = 1'b1;
    step();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_post_stall got=%b want=0", stall); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_post_busy got=%b want=0", md_busy); end
  endtask

  // lw $1 then add $2,$1,$1: one stall cycle, then tnew1 in M is not forwarded.
  task automatic test_lw_alu();
    do_reset();
    set_d(1'b1, 1'b1, 5'd1, 2'd2, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lwalu_issue got=%b want=0", stall); end
    step();
    set_d(1'b1, 1'b1, 5'd2, 2'd1, 5'd1, 5'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lwalu_stall got=%b want=1", stall); end
    step();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lwalu_release got=%b want=0", stall); end
    total++; if (fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL lwalu_fwd_rs got=%0d want=0", fwd_rs_sel); end
    total++; if (fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL lwalu_fwd_rt got=%0d want=0", fwd_rt_sel); end
  endtask

  // lw $1 then beq $1,$0: two stall cycles, then forward from W (sel 3).
  task automatic test_lw_beq();
    do_reset();
    set_d(1'b1, 1'b1, 5'd1, 2'd2, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    step();
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL beq_stall%0d got=%b want=1", k, stall); end
      step();
    end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL beq_release got=%b want=0", stall); end
    total++; if (fwd_rs_sel !== 2'd3) begin bad++; $display("FAIL beq_fwd_rs got=%0d want=3", fwd_rs_sel); end
    total++; if (fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL beq_fwd_rt got=%0d want=0", fwd_rt_sel); end
  endtask

  // Two writers of $3; only the younger one counts for the reader.
  task automatic test_shadow();
    do_reset();
    set_d(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    step();
    set_d(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    step();
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd3, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL shadow_sw_stall got=%b want=0", stall); end
    total++; if (fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL shadow_sw_fwd_rt got=%0d want=0", fwd_rt_sel); end
    step();
    // sw (we=0) now in E, younger addu (tnew0) in M, older addu in W.
    set_d(1'b1, 1'b1, 5'd5, 2'd1, 5'd3, 5'd0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    total++; if (fwd_rs_sel !== 2'd2) begin bad++; $display("FAIL shadow_fwd_m got=%0d want=2", fwd_rs_sel); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL shadow_fwd_stall got=%b want=0", stall); end
  endtask

  // Writes to $0 never create hazards; invalid D never stalls.
  task automatic test_zero_and_invalid();
    do_reset();
    set_d(1'b1, 1'b1, 5'd0, 2'd2, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    step();
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b want=0", stall); end
    total++; if (fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL zero_fwd_rs got=%0d want=0", fwd_rs_sel); end
    do_reset();
    set_d(1'b1, 1'b1, 5'd1, 2'd2, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    step();
    set_d(1'b0, 1'b0, 5'd0, 2'd0, 5'd1, 5'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL invalid_stall got=%b want=0", stall); end
    step();
    // lw now in M with tnew1; a valid tuse0 reader must stall.
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 5'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL invalid_then_valid got=%b want=1", stall); end
  endtask

  // mult issues; div waits behind it without reloading; mflo then waits DIV_LAT cycles.
  task automatic test_md();
    do_reset();
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 1'b0, 1'b1);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL md_mult_issue got=%b want=0", stall); end
    step();
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL md_div_wait%0d got=%b want=1", k, stall); end
      step();
    end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL md_div_issue got=%b want=0", stall); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL md_idle_busy got=%b want=0", md_busy); end
    step();
    set_d(1'b1, 1'b1, 5'd4, 2'd1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL md_busy%0d got=%b want=1", k, md_busy); end
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL md_mflo_wait%0d got=%b want=1", k, stall); end
      step();
    end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL md_done_busy got=%b want=0", md_busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL md_mflo_issue got=%b want=0", stall); end
  endtask

  // Async reset during a div count with lw in E clears every pending hazard immediately.
  task automatic test_reset_mid();
    do_reset();
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1);
    step();
    set_d(1'b1, 1'b1, 5'd1, 2'd2, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    step();
    set_d(1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 5'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rmid_pre_stall got=%b want=1", stall); end
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL rmid_pre_busy got=%b want=1", md_busy); end
    rst_n = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%b want=0", stall); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", md_busy); end
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rmid_release got=%b want=0", stall); end
    step();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rmid_after got=%b want=0", stall); end
    total++; if (fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL rmid_fwd got=%0d want=0", fwd_rs_sel); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_lw_alu();
    test_lw_beq();
    test_shadow();
    test_zero_and_invalid();
    test_md();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
